// File: rtl/fetch_pc_unit.sv
// Fetch program counter: BOOT/RUN/HALT sequencing, valid/ready request
// handshake, trap/branch redirects with a single pending slot.
module fetch_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              C_EXT        = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_target,
    input  logic            inst_compressed,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t          state;
    logic            outstanding;
    logic            pend_valid;
    logic            pend_trap;
    logic [XLEN-1:0] pend_target;

    logic            accept;
    logic            sel_valid;
    logic            sel_aligned;
    logic            sel_ok;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] step;

    always_comb begin
        fetch_valid = (state == RUN) && (!stall || outstanding);
        accept      = fetch_valid && fetch_ready;
        sel_valid   = trap || branch_taken;
        sel_target  = trap ? trap_target : branch_target;
        sel_aligned = !sel_target[0] && ((C_EXT != 0) || !sel_target[1]);
        sel_ok      = sel_valid && sel_aligned;
        step        = ((C_EXT != 0) && inst_compressed) ? XLEN'(2) : XLEN'(4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            outstanding <= 1'b0;
            misaligned  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_trap   <= 1'b0;
            pend_target <= '0;
        end else begin
            misaligned  <= sel_valid && !sel_aligned;
            outstanding <= fetch_valid && !fetch_ready;

            if (accept) begin
                if (sel_ok)
                    pc <= sel_target;
                else if (pend_valid)
                    pc <= pend_target;
                else
                    pc <= pc + step;
                pend_valid <= 1'b0;
                pend_trap  <= 1'b0;
            end else if (fetch_valid) begin
                // pc is frozen mid-handshake; a queued trap is never displaced by a branch
                if (sel_ok && (trap || !(pend_valid && pend_trap))) begin
                    pend_valid  <= 1'b1;
                    pend_trap   <= trap;
                    pend_target <= sel_target;
                end
            end else begin
                if (sel_ok)
                    pc <= sel_target;
                else if (pend_valid)
                    pc <= pend_target;
                pend_valid <= 1'b0;
                pend_trap  <= 1'b0;
            end

            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt && (!fetch_valid || accept))
                        state <= HALT;
                end
                HALT: begin
                    if (resume)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter XLEN, default 32, address width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, XLEN-bit PC value loaded on reset.
REQ-003 Parameter C_EXT, default 1, 1 = 16-bit instructions supported (+2 step, halfword-aligned targets legal).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  high = suppress issue of a new fetch request.
REQ-007 halt  input  1  request entry to HALT state.
REQ-008 resume  input  1  request exit from HALT state.
REQ-009 branch_taken  input  1  branch/jump redirect request.
REQ-010 branch_target  input  XLEN  branch/jump target address.
REQ-011 trap  input  1  trap redirect request, priority over branch.
REQ-012 trap_target  input  XLEN  trap handler address.
REQ-013 inst_compressed  input  1  instruction at pc is 16-bit; sampled only on fetch accept.
REQ-014 fetch_ready  input  1  instruction memory accepts the request this cycle.
REQ-015 fetch_valid  output  1  fetch request for address pc is valid.
REQ-016 pc  output  XLEN  current fetch address, registered.
REQ-017 misaligned  output  1  registered one-cycle pulse: a redirect target was rejected as misaligned.

Function
REQ-018 States: BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset deassertion, then RUN unconditionally.
REQ-019 fetch_valid SHALL be 0 in BOOT and HALT; in RUN it SHALL be 1 when stall=0 or a request is outstanding (fetch_valid=1, fetch_ready=0 last cycle).
REQ-020 Handshake: accept = fetch_valid & fetch_ready; once fetch_valid is 1, it and pc SHALL stay stable until accept, irrespective of stall, halt or redirects.
REQ-021 On accept, next pc priority: trap_target (trap=1) > branch_target (branch_taken=1) > pending redirect > pc + step.
REQ-022 step = 2 when C_EXT=1 and inst_compressed=1, else 4; addition wraps modulo 2^XLEN.
REQ-023 Redirect while fetch_valid=0: pc SHALL load the target at the next edge (any state incl. HALT), no pending entry created.
REQ-024 Redirect while fetch_valid=1 and fetch_ready=0: target SHALL be latched as pending; pc unchanged until accept.
REQ-025 Pending rules: same-cycle trap beats branch; newer redirect overwrites a pending branch; a branch SHALL NOT overwrite a pending trap; pending cleared on the accept that consumes it.
REQ-026 Target legality: bit 0 set is always misaligned; bit 1 set is misaligned when C_EXT=0; a misaligned redirect SHALL be ignored entirely and misaligned pulses high the next cycle.
REQ-027 halt=1 in RUN: enter HALT at next edge if no request outstanding, else at the edge of the accept cycle (accept completes normally).
REQ-028 resume=1 in HALT: enter RUN at next edge; halt and resume together in HALT: resume wins; halt and resume together in RUN: halt wins.
REQ-029 Pending redirect held across HALT is applied to pc on HALT entry.

Reset
REQ-030 reset asserted at any time, including mid-handshake: immediately pc=RESET_VECTOR, fetch_valid=0, misaligned=0, pending cleared, state=BOOT.
REQ-031 No request outstanding at reset is preserved; first fetch_valid=1 in the second cycle after reset deassertion.

Verification
REQ-032 Reset release, fetch_ready=1, inst_compressed=0, RESET_VECTOR=0x100 -> pc 0x100, 0x104, 0x108 on successive accepts; fetch_valid 0 during BOOT.
REQ-033 C_EXT=1, accepts with inst_compressed 1,0,1 from 0x0 -> pc 0x2, 0x6, 0x8; pc=0xFFFFFFFC +4 -> 0x0.
REQ-034 fetch_ready=0 at pc 0x40, branch to 0x80 then stall=1 -> pc and fetch_valid held; ready=1 -> next pc 0x80.
REQ-035 Outstanding request, trap to 0x1000 pending then branch to 0x200 -> on accept pc 0x1000; same-cycle trap+branch -> trap target.
REQ-036 C_EXT=0, branch to 0x102 -> pc unchanged, misaligned pulse one cycle; branch to 0x101 with C_EXT=1 -> same.
REQ-037 halt during outstanding request -> HALT only after accept; branch to 0x300 in HALT -> pc 0x300, fetch_valid 0; resume -> fetch at 0x300; async reset mid-wait -> pc=RESET_VECTOR same cycle.
